// File: rtl/i_cache.sv
// i_cache: direct-mapped, read-only instruction cache between the IF stage
// and the unified memory port. Lines are four 16-bit words. Hits are returned
// combinationally in the lookup cycle. A miss issues one line refill and waits
// for the memory's one-cycle input-ready pulse.
//
// Ports:
//   clk, reset_n     clock; synchronous active-low reset
//   i_mem_read       fetch request (level-held while stalled)
//   i_address        fetch word address
//   i_invalidate     one-cycle pulse, clears every valid bit
//   i_ready          fetch hit, i_data valid this cycle
//   i_data           fetched instruction word
//   i_cache_busy     refill outstanding
//   mem_read         refill request, held until mem_input_ready
//   mem_address      line-aligned refill address
//   mem_data         refill line, word k at bits [16k+15:16k]
//   mem_input_ready  one-cycle pulse, mem_data valid
//   num_miss         saturating refill counter
module i_cache #(
    parameter int INDEX_BITS = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_mem_read,
    input  logic [15:0] i_address,
    input  logic        i_invalidate,
    output logic        i_ready,
    output logic [15:0] i_data,
    output logic        i_cache_busy,
    output logic        mem_read,
    output logic [15:0] mem_address,
    input  logic [63:0] mem_data,
    input  logic        mem_input_ready,
    output logic [15:0] num_miss
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 14 - INDEX_BITS;

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state_q;
    logic [LINES-1:0]   valid_q;
    logic               mem_read_q;
    logic [15:0]        mem_address_q;
    logic [15:0]        num_miss_q;
    logic [15:0]        num_miss_d;
    logic               busy_q;
    // Set when an invalidate lands while a refill is in flight, so the
    // returning line is stored but left invalid.
    logic               discard_q;

    // Line storage is never reset; only the valid bits carry reset state.
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [63:0]        data_mem [LINES];

    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_W-1:0]      tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_W-1:0]      fill_tag;
    logic [63:0]           line;
    logic                  hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign offset     = i_address[1:0];
    assign index      = i_address[INDEX_BITS+1:2];
    assign tag        = i_address[15:INDEX_BITS+2];
    // The latched refill address is the single source of the fill target,
    // so a fetch address change during FILL cannot redirect the write.
    assign fill_index = mem_address_q[INDEX_BITS+1:2];
    assign fill_tag   = mem_address_q[15:INDEX_BITS+2];

    assign line       = data_mem[index];
    assign hit        = i_mem_read && valid_q[index] && (tag_mem[index] == tag);
    assign num_miss_d = sat_inc(num_miss_q);

    assign i_ready      = (state_q == IDLE) && hit;
    assign i_data       = line[{offset, 4'b0000} +: 16];
    assign i_cache_busy = busy_q;
    assign mem_read     = mem_read_q;
    assign mem_address  = mem_address_q;
    assign num_miss     = num_miss_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            num_miss_q    <= '0;
            busy_q        <= 1'b0;
            discard_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_invalidate) begin
                        valid_q <= '0;
                    end
                    if (i_mem_read && !hit) begin
                        state_q       <= FILL;
                        mem_read_q    <= 1'b1;
                        busy_q        <= 1'b1;
                        mem_address_q <= {i_address[15:2], 2'b00};
                        num_miss_q    <= num_miss_d;
                        discard_q     <= 1'b0;
                    end
                end
                FILL: begin
                    if (i_invalidate) begin
                        valid_q   <= '0;
                        discard_q <= 1'b1;
                    end
                    // The per-line write below overrides the bulk clear for
                    // the filled line only; an invalidate on this very edge
                    // still discards it.
                    if (mem_input_ready) begin
                        state_q             <= IDLE;
                        mem_read_q          <= 1'b0;
                        busy_q              <= 1'b0;
                        valid_q[fill_index] <= !(discard_q || i_invalidate);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && (state_q == FILL) && mem_input_ready) begin
            data_mem[fill_index] <= mem_data;
            tag_mem[fill_index]  <= fill_tag;
        end
    end

endmodule

// File: tb/tb_i_cache.sv
// Directed testbench for i_cache (INDEX_BITS = 2). The bench plays the
// pipeline and the memory; every expected value is hand-computed.
module tb_i_cache;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_mem_read;
    logic [15:0] i_address;
    logic        i_invalidate;
    logic        i_ready;
    logic [15:0] i_data;
    logic        i_cache_busy;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [63:0] mem_data;
    logic        mem_input_ready;
    logic [15:0] num_miss;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i_cache #(.INDEX_BITS(2)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_mem_read      (i_mem_read),
        .i_address       (i_address),
        .i_invalidate    (i_invalidate),
        .i_ready         (i_ready),
        .i_data          (i_data),
        .i_cache_busy    (i_cache_busy),
        .mem_read        (mem_read),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_input_ready (mem_input_ready),
        .num_miss        (num_miss)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs and samples happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory side: wait some cycles in FILL, then return the line.
    task automatic fill(input logic [63:0] d, input int waitc);
        repeat (waitc) step();
        mem_data        = d;
        mem_input_ready = 1'b1;
        step();
        mem_input_ready = 1'b0;
    endtask

    initial begin
        reset_n         = 1'b0;
        i_mem_read      = 1'b0;
        i_address       = 16'h0000;
        i_invalidate    = 1'b0;
        mem_data        = 64'h0;
        mem_input_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        #1;
        chk("rst_ready",   i_ready, 0);
        chk("rst_memread", mem_read, 0);
        chk("rst_memaddr", mem_address, 16'h0000);
        chk("rst_nmiss",   num_miss, 0);
        chk("rst_busy",    i_cache_busy, 0);

        // Cold miss on 0x0005
        i_mem_read = 1'b1;
        i_address  = 16'h0005;
        #1;
        chk("t1_miss_ready", i_ready, 0);
        step();
        chk("t1_memread",  mem_read, 1);
        chk("t1_memaddr",  mem_address, 16'h0004);
        chk("t1_busy",     i_cache_busy, 1);
        chk("t1_fill_rdy", i_ready, 0);
        fill(64'hDDDD_CCCC_BBBB_AAAA, 2);
        chk("t1_ready",   i_ready, 1);
        chk("t1_data",    i_data, 16'hBBBB);
        chk("t1_nmiss",   num_miss, 1);
        chk("t1_memread0", mem_read, 0);
        chk("t1_busy0",   i_cache_busy, 0);

        // Same-line hits
        i_address = 16'h0006;
        #1;
        chk("t2_ready6", i_ready, 1);
        chk("t2_data6",  i_data, 16'hCCCC);
        step();
        chk("t2_memread6", mem_read, 0);
        i_address = 16'h0007;
        #1;
        chk("t2_ready7", i_ready, 1);
        chk("t2_data7",  i_data, 16'hDDDD);
        step();
        chk("t2_memread7", mem_read, 0);
        chk("t2_nmiss",    num_miss, 1);

        // Conflict on index 1
        i_address = 16'h0014;
        #1;
        chk("t3_miss14", i_ready, 0);
        step();
        chk("t3_memaddr14", mem_address, 16'h0014);
        chk("t3_nmiss2",    num_miss, 2);
        fill(64'h4444_3333_2222_1111, 1);
        chk("t3_ready14", i_ready, 1);
        chk("t3_data14",  i_data, 16'h1111);
        i_address = 16'h0004;
        #1;
        chk("t3_miss04", i_ready, 0);
        step();
        chk("t3_memaddr04", mem_address, 16'h0004);
        chk("t3_nmiss3",    num_miss, 3);
        chk("t3_memread04", mem_read, 1);
        fill(64'hDDDD_CCCC_BBBB_AAAA, 0);
        chk("t3_data04", i_data, 16'hAAAA);

        // Branch flush during FILL
        i_address = 16'h0020;
        #1;
        chk("t4_miss20", i_ready, 0);
        step();
        chk("t4_nmiss4", num_miss, 4);
        step();
        step();
        i_address = 16'h0031;
        #1;
        chk("t4_memaddr_held", mem_address, 16'h0020);
        chk("t4_memread_held", mem_read, 1);
        fill(64'h8888_7777_6666_5555, 0);
        chk("t4_miss31", i_ready, 0);
        step();
        chk("t4_memaddr30", mem_address, 16'h0030);
        chk("t4_nmiss5",    num_miss, 5);
        fill(64'h0004_0003_0002_0001, 1);
        chk("t4_ready31", i_ready, 1);
        chk("t4_data31",  i_data, 16'h0002);

        // Reset mid-FILL, then a stale memory pulse
        i_address = 16'h0040;
        step();
        chk("t5_memread", mem_read, 1);
        chk("t5_nmiss6",  num_miss, 6);
        reset_n = 1'b0;
        step();
        reset_n    = 1'b1;
        i_mem_read = 1'b0;
        #1;
        chk("t5_memread0", mem_read, 0);
        chk("t5_nmiss0",   num_miss, 0);
        chk("t5_busy0",    i_cache_busy, 0);
        mem_data        = 64'hFFFF_EEEE_0000_1234;
        mem_input_ready = 1'b1;
        step();
        mem_input_ready = 1'b0;
        chk("t5_stale_memread", mem_read, 0);
        chk("t5_stale_nmiss",   num_miss, 0);
        i_mem_read = 1'b1;
        i_address  = 16'h0006;
        #1;
        chk("t5_old_invalid", i_ready, 0);
        i_address = 16'h0040;
        #1;
        chk("t5_reread_miss", i_ready, 0);
        step();
        chk("t5_nmiss1",   num_miss, 1);
        chk("t5_memaddr",  mem_address, 16'h0040);
        fill(64'hA3A3_A2A2_A1A1_A0A0, 0);
        chk("t5_data40", i_data, 16'hA0A0);

        // Invalidate in IDLE, coincident with a hit
        i_address = 16'h0008;
        #1;
        chk("t6_miss08", i_ready, 0);
        step();
        chk("t6_nmiss2", num_miss, 2);
        fill(64'h1234_5678_9ABC_DEF0, 1);
        i_invalidate = 1'b1;
        #1;
        chk("t6_inv_hit_ready", i_ready, 1);
        chk("t6_inv_hit_data",  i_data, 16'hDEF0);
        step();
        i_invalidate = 1'b0;
        #1;
        chk("t6_after_inv", i_ready, 0);
        step();
        chk("t6_nmiss3",   num_miss, 3);
        chk("t6_memaddr",  mem_address, 16'h0008);

        // Invalidate during FILL discards the line
        i_invalidate = 1'b1;
        step();
        i_invalidate = 1'b0;
        fill(64'h1234_5678_9ABC_DEF0, 1);
        chk("t6_discard_ready", i_ready, 0);
        step();
        chk("t6_nmiss4", num_miss, 4);

        // Invalidate on the same edge as mem_input_ready
        mem_data        = 64'h1234_5678_9ABC_DEF0;
        mem_input_ready = 1'b1;
        i_invalidate    = 1'b1;
        step();
        mem_input_ready = 1'b0;
        i_invalidate    = 1'b0;
        #1;
        chk("t6_edge_discard", i_ready, 0);
        step();
        chk("t6_nmiss5", num_miss, 5);
        fill(64'h1234_5678_9ABC_DEF0, 0);
        chk("t6_final_ready", i_ready, 1);
        chk("t6_final_data",  i_data, 16'hDEF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
